// File: rtl/hynoc_ingress_arbiter_pkg.sv
// Shared definitions for the HyNoC local ingress arbiter.
// Contents:
//   ST_IDLE/ST_ADDR/ST_BODY  FSM state encodings (also driven on the debug state output)
//   header_bit()             index of the header/end flag inside a flit
package hynoc_ingress_arbiter_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_ADDR = 2'd1;
  localparam logic [STATE_W-1:0] ST_BODY = 2'd2;

  // The flag sits just above the payload bits.
  function automatic int header_bit(input int payload_width);
    return payload_width;
  endfunction

endpackage

// File: rtl/hynoc_ingress_arbiter_if.sv
// Bundle between the local packet sources, the ingress arbiter and the router
// ingress FIFO.
// Signals:
//   req_valid[NB_REQ]             source i presents a flit
//   req_data[NB_REQ*FLIT_WIDTH]   flit of source i at [i*FLIT_WIDTH +: FLIT_WIDTH]
//   req_ready[NB_REQ]             flit of source i is taken this cycle
//   local_ingress_write           registered write strobe into the ingress FIFO
//   local_ingress_data            registered flit into the ingress FIFO
//   local_ingress_fifo_level      ingress FIFO occupancy
// Handshake: a flit moves on every cycle where req_valid[i] and req_ready[i]
// are both high; req_valid may rise or fall freely, req_data must be stable
// while req_valid is high, and req_ready never depends on the same source's
// req_valid in the same cycle.
// Modports: slave = arbiter side, master = sources/FIFO side.
interface hynoc_ingress_arbiter_if #(
  parameter int NB_REQ          = 4,
  parameter int FLIT_WIDTH      = 33,
  parameter int LOG2_FIFO_DEPTH = 5
) ();

  logic [NB_REQ-1:0]            req_valid;
  logic [NB_REQ*FLIT_WIDTH-1:0] req_data;
  logic [NB_REQ-1:0]            req_ready;
  logic                         local_ingress_write;
  logic [FLIT_WIDTH-1:0]        local_ingress_data;
  logic [LOG2_FIFO_DEPTH:0]     local_ingress_fifo_level;

  modport slave (
    input  req_valid,
    input  req_data,
    input  local_ingress_fifo_level,
    output req_ready,
    output local_ingress_write,
    output local_ingress_data
  );

  modport master (
    output req_valid,
    output req_data,
    output local_ingress_fifo_level,
    input  req_ready,
    input  local_ingress_write,
    input  local_ingress_data
  );

endinterface

// File: rtl/hynoc_ingress_arbiter_rr_picker.sv
// hynoc_rr_picker: combinational round-robin picker.
// Returns the one-hot index of the first set request at or after ptr,
// wrapping cyclically. Shared with the egress dispatcher.
// Ports:
//   req[NB_REQ]    request vector
//   ptr[PTR_W]     highest-priority index, must be < NB_REQ
//   winner[NB_REQ] one-hot winner, 0 when req is 0
module hynoc_rr_picker #(
  parameter int NB_REQ = 4,
  parameter int PTR_W  = $clog2(NB_REQ)
) (
  input  logic [NB_REQ-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NB_REQ-1:0] winner
);

  logic [2*NB_REQ-1:0] req_dbl;
  logic [2*NB_REQ-1:0] req_rot;
  logic [NB_REQ-1:0]   rot_lo;
  logic [NB_REQ-1:0]   iso;
  logic [2*NB_REQ-1:0] iso_dbl;

  // Rotate so that ptr lands on bit 0, isolate the lowest set bit, then rotate
  // back. Duplicating the vector makes both rotations plain shifts.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl >> ptr;
  assign rot_lo  = req_rot[NB_REQ-1:0];
  assign iso     = rot_lo & (-rot_lo);
  assign iso_dbl = {{NB_REQ{1'b0}}, iso} << ptr;
  assign winner  = iso_dbl[NB_REQ-1:0] | iso_dbl[2*NB_REQ-1:NB_REQ];

endmodule

// File: rtl/hynoc_ingress_arbiter.sv
// hynoc_ingress_arbiter: shares the router local ingress port between NB_REQ
// packet sources. Round-robin, packet-atomic: a granted source keeps the port
// until its end flit (first flagged flit after the address flits).
// Ports:
//   local_clk, local_srst   clock, synchronous active-high reset
//   ing (slave)             source handshake + ingress FIFO write/level
//   grant[NB_REQ]           one-hot current owner, 0 when idle
//   busy                    a packet is in flight
//   packet_count[32]        packets completely forwarded, wrapping
//   state_dbg               FSM state (ST_IDLE/ST_ADDR/ST_BODY)
module hynoc_ingress_arbiter
  import hynoc_ingress_arbiter_pkg::*;
#(
  parameter int NB_REQ           = 4,
  parameter int NB_ADDRESS_FLITS = 1,
  parameter int LOG2_FIFO_DEPTH  = 5,
  parameter int PAYLOAD_WIDTH    = 32
) (
  input  logic                 local_clk,
  input  logic                 local_srst,
  hynoc_ingress_arbiter_if.slave ing,
  output logic [NB_REQ-1:0]    grant,
  output logic                 busy,
  output logic [31:0]          packet_count,
  output logic [STATE_W-1:0]   state_dbg
);

  localparam int FLIT_WIDTH = PAYLOAD_WIDTH + 1;
  localparam int FLAG_BIT   = header_bit(PAYLOAD_WIDTH);
  localparam int PTR_W      = $clog2(NB_REQ);
  localparam int ADDR_W     = (NB_ADDRESS_FLITS > 1) ? $clog2(NB_ADDRESS_FLITS) : 1;

  // Two free entries are kept in reserve: one for the flit sitting in the
  // output register, one for the level input lagging the write by a cycle.
  localparam logic [LOG2_FIFO_DEPTH:0] SPACE_LIMIT =
    (LOG2_FIFO_DEPTH+1)'((1 << LOG2_FIFO_DEPTH) - 2);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NB_ADDRESS_FLITS - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(NB_REQ - 1);

  logic [STATE_W-1:0]    state;
  logic [ADDR_W-1:0]     addr_cnt;
  logic [PTR_W-1:0]      rr_ptr;
  logic                  space;
  logic [NB_REQ-1:0]     ready;
  logic                  accept;
  logic [FLIT_WIDTH-1:0] sel_flit;
  logic [PTR_W-1:0]      owner_idx;
  logic [NB_REQ-1:0]     winner;

  assign space         = ing.local_ingress_fifo_level < SPACE_LIMIT;
  assign ready         = grant & {NB_REQ{space & (state != ST_IDLE)}};
  assign ing.req_ready = ready;
  assign accept        = |(ing.req_valid & ready);
  assign busy          = (state != ST_IDLE);
  assign state_dbg     = state;

  // grant is one-hot (or zero), so OR-ing the selected lanes is a mux.
  always_comb begin
    sel_flit  = '0;
    owner_idx = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      if (grant[i]) begin
        sel_flit  = sel_flit | ing.req_data[i*FLIT_WIDTH +: FLIT_WIDTH];
        owner_idx = PTR_W'(i);
      end
    end
  end

  hynoc_rr_picker #(
    .NB_REQ (NB_REQ),
    .PTR_W  (PTR_W)
  ) u_picker (
    .req    (ing.req_valid),
    .ptr    (rr_ptr),
    .winner (winner)
  );

  always_ff @(posedge local_clk) begin
    if (local_srst) begin
      state                   <= ST_IDLE;
      grant                   <= '0;
      addr_cnt                <= '0;
      rr_ptr                  <= '0;
      packet_count            <= '0;
      ing.local_ingress_write <= 1'b0;
      ing.local_ingress_data  <= '0;
    end else begin
      // Output register: one-cycle source-to-port latency, data held otherwise.
      ing.local_ingress_write <= accept;
      if (accept) begin
        ing.local_ingress_data <= sel_flit;
      end

      case (state)
        ST_IDLE: begin
          // Arbitration cycle; no flit can be accepted here.
          if (|ing.req_valid) begin
            grant    <= winner;
            addr_cnt <= '0;
            state    <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          // The flag is meaningless on address flits.
          if (accept) begin
            if (addr_cnt == ADDR_LAST) begin
              state <= ST_BODY;
            end else begin
              addr_cnt <= addr_cnt + ADDR_W'(1);
            end
          end
        end
        ST_BODY: begin
          if (accept && sel_flit[FLAG_BIT]) begin
            grant        <= '0;
            rr_ptr       <= (owner_idx == PTR_LAST) ? '0 : owner_idx + PTR_W'(1);
            packet_count <= packet_count + 32'd1;
            state        <= ST_IDLE;
          end
        end
        default: begin
          grant <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
